loop_ctrl: RTL and testbench

//  Sequences the loop-address stack for the BF core's '[' and ']' instructions.
//  - Pushes loop-start addresses, and pops them on loop exit.
//  - Supplies jump targets for taken back-branches.
//  - Runs the forward-skip scan when '[' is reached with a zero cell.
//  - Sits between the instruction decoder / PC logic and the stack instance.
//    It is the only driver of the stack's push_en / pop_en / pushd.
//

---
 rtl/loop_ctrl.sv | 164 ++++++++++++++++
 tb/tb_loop_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/loop_ctrl.sv
// Loop-address stack sequencer for the BF core's '[' and ']' instructions.
// Drives the stack strobes and PC redirects, and runs the forward-skip scan.
module loop_ctrl #(
  parameter int PC_WIDTH    = 8,
  parameter int DEPTH_WIDTH = 5,
  parameter int SKIP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic                   op_open,
  input  logic                   op_close,
  input  logic [PC_WIDTH-1:0]    op_pc,
  input  logic                   cell_zero,
  output logic                   skip,
  output logic                   pc_load,
  output logic [PC_WIDTH-1:0]    pc_target,
  output logic [PC_WIDTH-1:0]    stk_pushd,
  output logic                   stk_push_en,
  output logic                   stk_pop_en,
  input  logic [PC_WIDTH-1:0]    stk_top,
  output logic [DEPTH_WIDTH:0]   loop_depth,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SKIP  = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_OVF   = 2'b01;
  localparam logic [1:0] CODE_UNF   = 2'b10;
  localparam logic [1:0] CODE_SKOVF = 2'b11;

  localparam logic [DEPTH_WIDTH:0]  DEPTH_ZERO = {(DEPTH_WIDTH+1){1'b0}};
  localparam logic [DEPTH_WIDTH:0]  DEPTH_ONE  = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [DEPTH_WIDTH:0]  DEPTH_MAX  = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [SKIP_WIDTH-1:0] SKIP_ZERO  = {SKIP_WIDTH{1'b0}};
  localparam logic [SKIP_WIDTH-1:0] SKIP_ONE   = {{(SKIP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SKIP_WIDTH-1:0] SKIP_MAX   = {SKIP_WIDTH{1'b1}};
  localparam logic [PC_WIDTH-1:0]   PC_ONE     = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_q, state_d;
  logic [DEPTH_WIDTH:0]  depth_q, depth_d;
  logic [SKIP_WIDTH-1:0] skip_cnt_q, skip_cnt_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  accept_s;
  logic                  push_s, pop_s, load_s;

  // A strobe raised while rst is high would be dropped by the stack anyway;
  // gating it here keeps the outputs clean during reset.
  assign accept_s = op_valid & op_ready & ~rst;

  // Next-state, counter and strobe decode for the accepted instruction.
  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    skip_cnt_d = skip_cnt_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    load_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (op_open) begin
            if (cell_zero) begin
              skip_cnt_d = SKIP_ONE;
              state_d    = ST_SKIP;
            end else if (depth_q == DEPTH_MAX) begin
              state_d    = ST_ERROR;
              err_d      = 1'b1;
              err_code_d = CODE_OVF;
            end else begin
              push_s  = 1'b1;
              depth_d = depth_q + DEPTH_ONE;
            end
          end else if (op_close) begin
            if (depth_q == DEPTH_ZERO) begin
              state_d    = ST_ERROR;
              err_d      = 1'b1;
              err_code_d = CODE_UNF;
            end else if (cell_zero) begin
              pop_s   = 1'b1;
              depth_d = depth_q - DEPTH_ONE;
            end else begin
              load_s = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SKIP: begin
        // Nesting is tracked only by the counter; the stack is left alone.
        if (accept_s) begin
          if (op_open) begin
            if (skip_cnt_q == SKIP_MAX) begin
              state_d    = ST_ERROR;
              err_d      = 1'b1;
              err_code_d = CODE_SKOVF;
            end else begin
              skip_cnt_d = skip_cnt_q + SKIP_ONE;
            end
          end else if (op_close) begin
            skip_cnt_d = skip_cnt_q - SKIP_ONE;
            if (skip_cnt_q == SKIP_ONE) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_SKIP;
            end
          end else begin
            state_d = ST_SKIP;
          end
        end else begin
          state_d = ST_SKIP;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        // Unreachable encoding: lock up in ERROR until rst.
        state_d = ST_ERROR;
        err_d   = 1'b1;
      end
    endcase
  end

  // State, counters and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      depth_q    <= DEPTH_ZERO;
      skip_cnt_q <= SKIP_ZERO;
      err_q      <= 1'b0;
      err_code_q <= CODE_NONE;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      skip_cnt_q <= skip_cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign op_ready    = (state_q != ST_ERROR);
  assign skip        = (state_q == ST_SKIP);
  assign pc_load     = load_s;
  assign pc_target   = stk_top + PC_ONE;
  assign stk_pushd   = op_pc;
  assign stk_push_en = push_s;
  assign stk_pop_en  = pop_s;
  assign loop_depth  = depth_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_loop_ctrl.sv
// Directed bench for loop_ctrl: a behavioural stack drives stk_top, and a
// reference model queues expectations that are checked as the DUT responds.
module tb_loop_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid, op_open, op_close, cell_zero;
  logic [7:0] op_pc;
  logic       op_ready, skip, pc_load, stk_push_en, stk_pop_en, err;
  logic [7:0] pc_target, stk_pushd, stk_top;
  logic [5:0] loop_depth;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  loop_ctrl dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_open(op_open), .op_close(op_close), .op_pc(op_pc), .cell_zero(cell_zero),
    .skip(skip), .pc_load(pc_load), .pc_target(pc_target), .stk_pushd(stk_pushd),
    .stk_push_en(stk_push_en), .stk_pop_en(stk_pop_en), .stk_top(stk_top),
    .loop_depth(loop_depth), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Behavioural stack driven only by the DUT strobes.
  logic [7:0] env_mem [0:31];
  logic [5:0] env_sp;
  always @(posedge clk) begin
    if (rst) env_sp <= 6'd0;
    else if (stk_push_en) begin
      env_mem[env_sp[4:0]] <= stk_pushd;
      env_sp <= env_sp + 6'd1;
    end else if (stk_pop_en) env_sp <= env_sp - 6'd1;
  end
  assign stk_top = (env_sp == 6'd0) ? 8'h00 : env_mem[5'(env_sp - 6'd1)];

  typedef struct packed {
    logic       ready, skip, push, pop, load;
    logic [7:0] target, pushd;
    logic [5:0] depth;
    logic       err;
    logic [1:0] code;
    logic       post_ready, post_skip;
  } exp_t;

  exp_t sb[$];

  // Reference model: 0 idle, 1 skip, 2 error
  int         m_state, m_depth, m_cnt;
  logic       m_err;
  logic [1:0] m_code;
  logic [7:0] m_stk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_depth = 0; m_cnt = 0; m_err = 1'b0; m_code = 2'b00;
    m_stk.delete();
  endtask

  task automatic do_reset(input logic op_during);
    rst = 1'b1;
    op_valid = op_during; op_open = 1'b1; op_close = 1'b0; op_pc = 8'h77; cell_zero = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0; op_open = 1'b0;
    model_reset();
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_skip", 32'(skip), 32'd0);
    chk("rst_strobes", 32'({pc_load, stk_push_en, stk_pop_en}), 32'd0);
    chk("rst_depth", 32'(loop_depth), 32'd0);
    chk("rst_err", 32'({err, err_code}), 32'd0);
  endtask

  task automatic step(input logic v, input logic o, input logic c,
                      input logic [7:0] pc, input logic cz);
    exp_t e, g;
    logic acc;
    e = '0;
    e.ready = (m_state != 2);
    e.skip  = (m_state == 1);
    e.pushd = pc;
    e.target = (m_stk.size() > 0) ? m_stk[$] + 8'd1 : 8'd1;
    acc = v & e.ready;
    if (acc) begin
      case (m_state)
        0: begin
          if (o) begin
            if (cz) begin m_cnt = 1; m_state = 1; end
            else if (m_depth == 32) begin m_state = 2; m_err = 1'b1; m_code = 2'b01; end
            else begin e.push = 1'b1; m_stk.push_back(pc); m_depth++; end
          end else if (c) begin
            if (m_depth == 0) begin m_state = 2; m_err = 1'b1; m_code = 2'b10; end
            else if (cz) begin e.pop = 1'b1; void'(m_stk.pop_back()); m_depth--; end
            else e.load = 1'b1;
          end
        end
        1: begin
          if (o) begin
            if (m_cnt == 255) begin m_state = 2; m_err = 1'b1; m_code = 2'b11; end
            else m_cnt++;
          end else if (c) begin
            m_cnt--;
            if (m_cnt == 0) m_state = 0;
          end
        end
        default: ;
      endcase
    end
    e.depth = 6'(m_depth); e.err = m_err; e.code = m_code;
    e.post_ready = (m_state != 2); e.post_skip = (m_state == 1);
    sb.push_back(e);

    op_valid = v; op_open = o; op_close = c; op_pc = pc; cell_zero = cz;
    @(negedge clk);
    g = sb.pop_front();
    chk("op_ready", 32'(op_ready), 32'(g.ready));
    chk("skip", 32'(skip), 32'(g.skip));
    chk("push_en", 32'(stk_push_en), 32'(g.push));
    chk("pop_en", 32'(stk_pop_en), 32'(g.pop));
    chk("pc_load", 32'(pc_load), 32'(g.load));
    chk("pushd", 32'(stk_pushd), 32'(g.pushd));
    if (g.load) chk("pc_target", 32'(pc_target), 32'(g.target));
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk("depth", 32'(loop_depth), 32'(g.depth));
    chk("err", 32'(err), 32'(g.err));
    chk("err_code", 32'(err_code), 32'(g.code));
    chk("post_ready", 32'(op_ready), 32'(g.post_ready));
    chk("post_skip", 32'(skip), 32'(g.post_skip));
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_open = 1'b0; op_close = 1'b0;
    op_pc = 8'h00; cell_zero = 1'b0;
    model_reset();
    do_reset(1'b0);

    // 1: push then taken back-branch
    step(1'b1, 1'b1, 1'b0, 8'h10, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h18, 1'b0);
    chk("t1_target", 32'(pc_target), 32'h11);
    step(1'b1, 1'b0, 1'b1, 8'h18, 1'b1);

    // 2: nested pushes and pops
    step(1'b1, 1'b1, 1'b0, 8'h02, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h05, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h08, 1'b1);
    chk("t2_stk_top", 32'(stk_top), 32'h02);
    step(1'b0, 1'b0, 1'b1, 8'h09, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'h09, 1'b1);

    // 3: forward skip over a nested body
    step(1'b1, 1'b1, 1'b0, 8'h20, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h21, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h22, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'h23, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h24, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h25, 1'b0);

    // open wins over close; target wraps
    step(1'b1, 1'b1, 1'b1, 8'h40, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h41, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h03, 1'b0);
    chk("wrap_target", 32'(pc_target), 32'h00);
    step(1'b1, 1'b0, 1'b1, 8'h03, 1'b1);

    // skip counter overflow
    step(1'b1, 1'b1, 1'b0, 8'h30, 1'b1);
    for (int i = 0; i < 254; i++) step(1'b1, 1'b1, 1'b0, 8'h31, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h32, 1'b0);
    chk("skovf_code", 32'(err_code), 32'h3);
    do_reset(1'b1);

    // 4: stack overflow on the 33rd push
    for (int i = 0; i < 33; i++) step(1'b1, 1'b1, 1'b0, 8'(i), 1'b0);
    chk("ovf_depth", 32'(loop_depth), 32'd32);
    step(1'b1, 1'b1, 1'b0, 8'h60, 1'b0);
    do_reset(1'b0);

    // 5: underflow, then reset clears it
    step(1'b1, 1'b0, 1'b1, 8'h50, 1'b1);
    chk("unf_code", 32'(err_code), 32'h2);
    do_reset(1'b1);

    // 6: reset during skip, then a normal push
    step(1'b1, 1'b1, 1'b0, 8'h70, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h71, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h72, 1'b1);
    do_reset(1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h73, 1'b0);
    chk("t6_top", 32'(stk_top), 32'h73);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
